mmwave_cfg_loader: RTL and testbench
====================================

MMWAVE_CFG_LOADER -- requirements
Module: mmwave_cfg_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, max idle cycles between accepted bytes inside a frame.
REQ-002 SHALL have parameter HDR_BYTE, default 8'hA5, frame start marker.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port rx_data_i, input, 8, config byte stream (from UDP receive path).
REQ-006 SHALL have port rx_valid_i, input, 1, rx_data_i valid.
REQ-007 SHALL have port rx_ready_o, output, 1, byte accepted when rx_valid_i && rx_ready_o.
REQ-008 SHALL have port reg_wr_en_o, output, 1, one-cycle register-file write strobe.
REQ-009 SHALL have port reg_wr_index_o, output, 3, register-file index (0..5).
REQ-010 SHALL have port reg_wr_value_o, output, 64, register-file write value.
REQ-011 SHALL have port busy_o, output, 1, high when FSM not in IDLE.
REQ-012 SHALL have port frame_ok_cnt_o, output, 16, count of frames written.
REQ-013 SHALL have port frame_err_cnt_o, output, 16, count of rejected or timed-out frames.

Function
REQ-014 SHALL parse frames: HDR_BYTE, index byte, 8 data bytes MSB first, checksum byte (11 bytes).
REQ-015 SHALL compute checksum as XOR of index byte and the 8 data bytes.
REQ-016 SHALL implement states IDLE, INDEX, DATA, CHECK, WRITE.
REQ-017 IDLE: accepted byte == HDR_BYTE -> INDEX; any other byte discarded silently, no counter change.
REQ-018 INDEX: accepted byte latched as index -> DATA with byte counter cleared.
REQ-019 DATA: each accepted byte shifts into a 64-bit value register; after the 8th byte (counter 7) -> CHECK.
REQ-020 CHECK: accepted byte matching checksum with index <= 5 -> WRITE; otherwise -> IDLE and frame_err_cnt_o increments.
REQ-021 WRITE: reg_wr_en_o high for exactly one cycle, then -> IDLE, and frame_ok_cnt_o increments in the same cycle.
REQ-022 Latency: checksum byte accepted in cycle N gives reg_wr_en_o high in cycle N+1.
REQ-023 rx_ready_o SHALL be 1 in all states except WRITE.
REQ-024 reg_wr_index_o/reg_wr_value_o SHALL update only on entry to WRITE and hold between strobes.
REQ-025 Timeout: in INDEX/DATA/CHECK, an idle counter counts cycles with no accepted byte and clears on each accepted byte.
REQ-026 When the idle counter reaches TIMEOUT_CYCLES, the FSM SHALL go to IDLE, frame_err_cnt_o increments, and the partial frame is discarded.
REQ-027 A byte accepted in the same cycle as timeout expiry SHALL take priority, so no timeout occurs.
REQ-028 Both frame counters SHALL saturate at 16'hFFFF.
REQ-029 HDR_BYTE received inside a frame SHALL be treated as ordinary data; there is no resynchronisation mid-frame.

Reset
REQ-030 While rst_n == 0 at a clk edge: FSM -> IDLE; every output reg_wr_en_o, reg_wr_index_o, reg_wr_value_o, busy_o, frame_ok_cnt_o, frame_err_cnt_o -> 0; rx_ready_o = 1 from the first cycle after reset.
REQ-031 Reset mid-frame SHALL discard the partial frame without any write or counter change.

Structure
REQ-032 The shared package SHALL hold the state encoding, HDR_BYTE default, NUM_CFG_REGS = 6, and frame length constants.
REQ-033 One sub-module SHALL be used, mmwave_sat_cnt (16-bit saturating incrementer), instantiated twice.

Verification
REQ-034 Frame A5 02 00 00 00 00 00 4C 4B 40 45 -> one reg_wr_en_o pulse, index 2, value 64'h00000000004C4B40, ok=1, err=0.
REQ-035 Same frame with checksum 44 -> no strobe, err=1, FSM back in IDLE.
REQ-036 Bytes 00 FF before a valid index-0 frame with data ..00 0B and checksum 0B -> exactly one write (index 0, value 64'h0B), err=0.
REQ-037 Index byte 06 with correct checksum -> no strobe, err=1.
REQ-038 Stop after 4 bytes for TIMEOUT_CYCLES (1000) cycles -> IDLE and err=1; a following valid frame is written correctly.
REQ-039 rst_n low for one cycle after byte 6 of a frame -> no write, counters 0, and the next full frame is written.

Source files
------------

// File: rtl/mmwave_cfg_loader_pkg.sv
// Shared definitions for the mmWave configuration loader: FSM encoding,
// frame layout constants and the register-write record.
package mmwave_cfg_loader_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INDEX = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    // Frame layout: header, index, DATA_BYTES payload bytes (MSB first), checksum
    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
    localparam int         NUM_CFG_REGS     = 6;
    localparam int         DATA_BYTES       = 8;
    localparam int         FRAME_BYTES      = DATA_BYTES + 3;

    // One pending register-file write
    typedef struct packed {
        logic [2:0]  index;
        logic [63:0] value;
    } cfg_wr_t;

    // True when a received index addresses an existing configuration register
    function automatic logic idx_in_range(input logic [7:0] idx);
        return idx < 8'(NUM_CFG_REGS);
    endfunction

endpackage

// File: rtl/mmwave_sat_cnt.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module mmwave_sat_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;

    // Count increment requests, holding at 16'hFFFF once reached
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mmwave_cfg_loader.sv
// Parses framed configuration bytes from the UDP receive path and issues
// one register-file write per frame whose checksum and index are valid.
module mmwave_cfg_loader
    import mmwave_cfg_loader_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter logic [7:0] HDR_BYTE       = HDR_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        reg_wr_en_o,
    output logic [2:0]  reg_wr_index_o,
    output logic [63:0] reg_wr_value_o,
    output logic        busy_o,
    output logic [15:0] frame_ok_cnt_o,
    output logic [15:0] frame_err_cnt_o
);

    // The idle counter only has to reach TIMEOUT_CYCLES-1: the expiring
    // cycle itself is detected combinationally.
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] TMO_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]        state_q,    state_d;
    logic [7:0]        index_q,    index_d;
    logic [63:0]       value_q,    value_d;
    logic [7:0]        csum_q,     csum_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    cfg_wr_t           wr_q,       wr_d;
    logic              accept;
    logic              ok_inc;
    logic              err_inc;

    assign rx_ready_o     = (state_q != ST_WRITE);
    assign accept         = rx_valid_i && rx_ready_o;
    assign busy_o         = (state_q != ST_IDLE);
    assign reg_wr_en_o    = (state_q == ST_WRITE);
    assign reg_wr_index_o = wr_q.index;
    assign reg_wr_value_o = wr_q.value;

    // Frame parser next-state logic; an accepted byte always beats timeout
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        value_d    = value_q;
        csum_d     = csum_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        wr_d       = wr_q;
        ok_inc     = 1'b0;
        err_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (accept && (rx_data_i == HDR_BYTE)) begin
                    state_d = ST_INDEX;
                end
            end
            ST_INDEX, ST_DATA, ST_CHECK: begin
                if (accept) begin
                    idle_cnt_d = '0;
                    if (state_q == ST_INDEX) begin
                        index_d    = rx_data_i;
                        csum_d     = rx_data_i;
                        byte_cnt_d = '0;
                        state_d    = ST_DATA;
                    end else if (state_q == ST_DATA) begin
                        value_d    = {value_q[55:0], rx_data_i};
                        csum_d     = csum_q ^ rx_data_i;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        if (byte_cnt_q == 3'(DATA_BYTES - 1)) begin
                            state_d = ST_CHECK;
                        end
                    end else begin
                        if ((rx_data_i == csum_q) && idx_in_range(index_q)) begin
                            wr_d.index = index_q[2:0];
                            wr_d.value = value_q;
                            state_d    = ST_WRITE;
                        end else begin
                            err_inc = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end else if (idle_cnt_q == TMO_LAST) begin
                    idle_cnt_d = '0;
                    err_inc    = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            ST_WRITE: begin
                ok_inc  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Parser state registers; reset drops any partial frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            value_q    <= '0;
            csum_q     <= '0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            value_q    <= value_d;
            csum_q     <= csum_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            wr_q       <= wr_d;
        end
    end

    mmwave_sat_cnt u_ok_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (ok_inc),
        .cnt_o (frame_ok_cnt_o)
    );

    mmwave_sat_cnt u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (err_inc),
        .cnt_o (frame_err_cnt_o)
    );

endmodule

// File: tb/tb_mmwave_cfg_loader.sv
// Directed bench for mmwave_cfg_loader: a table of frames plus hand-written
// timeout and reset sequences. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_mmwave_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [2:0]  wr_index;
    logic [63:0] wr_value;
    logic        busy;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    mmwave_cfg_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_data_i       (rx_data),
        .rx_valid_i      (rx_valid),
        .rx_ready_o      (rx_ready),
        .reg_wr_en_o     (wr_en),
        .reg_wr_index_o  (wr_index),
        .reg_wr_value_o  (wr_value),
        .busy_o          (busy),
        .frame_ok_cnt_o  (ok_cnt),
        .frame_err_cnt_o (err_cnt)
    );

    typedef struct {
        string       name;
        int          npre;
        logic [7:0]  pre0;
        logic [7:0]  pre1;
        logic [7:0]  idx;
        logic [63:0] val;
        logic [7:0]  cs;
        logic        exp_wr;
    } vec_t;

    vec_t vecs[6];

    int          n_vec  = 0;
    int          n_fail = 0;
    int          strobes = 0;
    int          exp_strobes = 0;
    logic [15:0] exp_ok = 16'd0;
    logic [15:0] exp_err = 16'd0;
    logic [2:0]  exp_idx = 3'd0;
    logic [63:0] exp_val = 64'd0;

    // Count every write strobe the design issues
    always @(negedge clk) begin
        if (rst_n && wr_en) strobes <= strobes + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Present one byte at a falling edge; returns at the next falling edge
    task automatic send_byte(input logic [7:0] b);
        if (!rx_ready) @(negedge clk);
        if (!rx_ready) chk("ready_wait", {63'd0, rx_ready}, 64'd1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] idx, input logic [63:0] val, input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(idx);
        for (int i = 7; i >= 0; i--) send_byte(val[i*8 +: 8]);
        send_byte(cs);
    endtask

    // Checks the cycle after the checksum byte and the cycle after that
    task automatic check_after(input string name, input logic exp_wr);
        chk({name, ".strobe"}, {63'd0, wr_en}, {63'd0, exp_wr});
        if (exp_wr) chk({name, ".ready_in_write"}, {63'd0, rx_ready}, 64'd0);
        @(negedge clk);
        chk({name, ".strobe_off"}, {63'd0, wr_en}, 64'd0);
        chk({name, ".busy"}, {63'd0, busy}, 64'd0);
        chk({name, ".ok_cnt"}, {48'd0, ok_cnt}, {48'd0, exp_ok});
        chk({name, ".err_cnt"}, {48'd0, err_cnt}, {48'd0, exp_err});
        chk({name, ".index"}, {61'd0, wr_index}, {61'd0, exp_idx});
        chk({name, ".value"}, wr_value, exp_val);
        chk({name, ".strobes"}, 64'(strobes), 64'(exp_strobes));
    endtask

    task automatic expect_frame(input logic exp_wr, input logic [7:0] idx, input logic [63:0] val);
        if (exp_wr) begin
            exp_ok++;
            exp_strobes++;
            exp_idx = idx[2:0];
            exp_val = val;
        end else begin
            exp_err++;
        end
    endtask

    initial begin
        vecs[0] = '{"basic",       0, 8'h00, 8'h00, 8'h02, 64'h00000000004C4B40, 8'h45, 1'b1};
        vecs[1] = '{"bad_csum",    0, 8'h00, 8'h00, 8'h02, 64'h00000000004C4B40, 8'h44, 1'b0};
        vecs[2] = '{"junk_prefix", 2, 8'h00, 8'hFF, 8'h00, 64'h000000000000000B, 8'h0B, 1'b1};
        vecs[3] = '{"bad_index",   0, 8'h00, 8'h00, 8'h06, 64'h0000000000000001, 8'h07, 1'b0};
        vecs[4] = '{"hdr_in_data", 0, 8'h00, 8'h00, 8'h05, 64'hA5A50000000000A5, 8'hA0, 1'b1};
        vecs[5] = '{"pattern",     0, 8'h00, 8'h00, 8'h01, 64'h0123456789ABCDEF, 8'h01, 1'b1};

        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("reset.ready",  {63'd0, rx_ready}, 64'd1);
        chk("reset.busy",   {63'd0, busy}, 64'd0);
        chk("reset.wr_en",  {63'd0, wr_en}, 64'd0);
        chk("reset.ok",     {48'd0, ok_cnt}, 64'd0);
        chk("reset.err",    {48'd0, err_cnt}, 64'd0);
        chk("reset.value",  wr_value, 64'd0);

        // Table of whole frames
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].npre > 0) send_byte(vecs[v].pre0);
            if (vecs[v].npre > 1) send_byte(vecs[v].pre1);
            if (vecs[v].npre > 0) chk({vecs[v].name, ".junk_idle"}, {63'd0, busy}, 64'd0);
            send_frame(vecs[v].idx, vecs[v].val, vecs[v].cs);
            expect_frame(vecs[v].exp_wr, vecs[v].idx, vecs[v].val);
            check_after(vecs[v].name, vecs[v].exp_wr);
        end

        // Byte arriving in the very cycle the timeout would expire wins
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (999) @(negedge clk);
        chk("tmo_edge.still_busy", {63'd0, busy}, 64'd1);
        chk("tmo_edge.err", {48'd0, err_cnt}, {48'd0, exp_err});
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h74);
        expect_frame(1'b1, 8'h03, 64'h0000112233445566);
        check_after("tmo_edge", 1'b1);

        // Full timeout after 4 bytes, then a good frame
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (999) @(negedge clk);
        chk("timeout.before", {63'd0, busy}, 64'd1);
        @(negedge clk);
        exp_err++;
        chk("timeout.idle", {63'd0, busy}, 64'd0);
        chk("timeout.err", {48'd0, err_cnt}, {48'd0, exp_err});
        send_frame(8'h02, 64'h00000000004C4B40, 8'h45);
        expect_frame(1'b1, 8'h02, 64'h00000000004C4B40);
        check_after("after_timeout", 1'b1);

        // Reset pulse after six bytes of a frame
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_ok  = 16'd0;
        exp_err = 16'd0;
        exp_idx = 3'd0;
        exp_val = 64'd0;
        chk("midreset.busy",  {63'd0, busy}, 64'd0);
        chk("midreset.ok",    {48'd0, ok_cnt}, 64'd0);
        chk("midreset.err",   {48'd0, err_cnt}, 64'd0);
        chk("midreset.value", wr_value, 64'd0);
        repeat (3) @(negedge clk);
        chk("midreset.no_write", 64'(strobes), 64'(exp_strobes));
        send_frame(8'h00, 64'h000000000000000B, 8'h0B);
        expect_frame(1'b1, 8'h00, 64'h000000000000000B);
        check_after("after_reset", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
